// File: rtl/jk_op_arbiter_pkg.sv
// Shared types and helpers for the JK op arbiter: op codes, FSM states,
// op-to-drive decode and expected readback value.
`timescale 1ns/1ps
package jk_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_RST  = 2'b01,
        OP_SET  = 2'b10,
        OP_TGL  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_DRIVE  = 2'b01,
        S_VERIFY = 2'b10,
        S_RESP   = 2'b11
    } state_t;

    // Returns {j,k} for an op
    function automatic logic [1:0] op_to_jk(input op_t op);
        logic [1:0] jk;
        case (op)
            OP_HOLD: jk = 2'b00;
            OP_RST:  jk = 2'b01;
            OP_SET:  jk = 2'b10;
            default: jk = 2'b11;
        endcase
        return jk;
    endfunction

    // Value q must take after the op has been applied to a flop holding q_start
    function automatic logic exp_q(input op_t op, input logic q_start);
        logic e;
        case (op)
            OP_HOLD: e = q_start;
            OP_RST:  e = 1'b0;
            OP_SET:  e = 1'b1;
            default: e = ~q_start;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/jk_op_arbiter_if.sv
// Requester-side bus of the JK op arbiter: request/op in, grant/done/status out.
`timescale 1ns/1ps
interface jk_req_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] op;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_id;
    logic [NREQ-1:0]   done;
    logic              err;
    logic              busy;

    // Requester logic drives req/op
    modport master (
        output req, op,
        input  grant, grant_id, done, err, busy
    );

    // Arbiter consumes req/op and reports transaction status
    modport slave (
        input  req, op,
        output grant, grant_id, done, err, busy
    );
endinterface

// File: rtl/jk_op_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping at NREQ.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any_req
);
    logic w_found;
    int   w_idx;

    // Scan requesters starting at the pointer and stop at the first hit
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        any_req = |req;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = int'(rr_ptr) + i;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!w_found && req[w_idx]) begin
                w_found     = 1'b1;
                gnt[w_idx]  = 1'b1;
                gnt_id      = IDW'(w_idx);
            end
        end
    end
endmodule

// File: rtl/jkff.sv
// Plain JK flip-flop: 00 hold, 01 reset, 10 set, 11 toggle on rising clk.
`timescale 1ns/1ps
module jkff (
    input  logic clk,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);
    // JK next-state update
    always_ff @(posedge clk) begin
        case ({j, k})
            2'b00:   q <= q;
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            default: q <= ~q;
        endcase
    end

    assign q_bar = ~q;
endmodule

// File: rtl/jk_op_arbiter.sv
// Shares one JK flip-flop between NREQ requesters. Each grant runs
// IDLE -> DRIVE -> VERIFY -> RESP: j/k are driven for one cycle, q is read
// back and compared with the value the op should have produced.
`timescale 1ns/1ps
module jk_op_arbiter
    import jk_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic       clk,
    input  logic       reset,
    jk_req_if.slave    bus,
    output logic       j,
    output logic       k,
    input  logic       q
);
    state_t            r_state;
    logic [IDW-1:0]    r_rr_ptr;
    logic [NREQ-1:0]   r_grant;
    logic [IDW-1:0]    r_grant_id;
    logic [NREQ-1:0]   r_done;
    logic              r_err;
    logic              r_busy;
    logic              r_j;
    logic              r_k;
    op_t               r_op;
    logic              r_q_start;
    logic              r_expected;

    logic [NREQ-1:0]   w_gnt;
    logic [IDW-1:0]    w_gnt_id;
    logic              w_any_req;
    op_t               w_op;
    logic [1:0]        w_jk;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req     (bus.req),
        .rr_ptr  (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_id  (w_gnt_id),
        .any_req (w_any_req)
    );

    assign w_op = op_t'(bus.op[2*w_gnt_id +: 2]);
    assign w_jk = op_to_jk(w_op);

    // Control FSM and all externally visible registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_j        <= 1'b0;
            r_k        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant    <= w_gnt;
                        r_grant_id <= w_gnt_id;
                        r_j        <= w_jk[1];
                        r_k        <= w_jk[0];
                        r_busy     <= 1'b1;
                        r_state    <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_j     <= 1'b0;
                    r_k     <= 1'b0;
                    r_state <= S_VERIFY;
                end
                S_VERIFY: begin
                    // grant is one-hot on the grantee, so it doubles as the done mask
                    r_done  <= r_grant;
                    r_err   <= (q != r_expected);
                    r_state <= S_RESP;
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= '0;
                    r_err   <= 1'b0;
                    r_rr_ptr <= (r_grant_id == IDW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Transaction data: op and starting q captured at grant, expected q computed in DRIVE
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_any_req) begin
            r_op      <= w_op;
            r_q_start <= q;
        end
        if (r_state == S_DRIVE) begin
            r_expected <= exp_q(r_op, r_q_start);
        end
    end

    assign bus.grant    = r_grant;
    assign bus.grant_id = r_grant_id;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.busy     = r_busy;
    assign j            = r_j;
    assign k            = r_k;
endmodule

// File: tb/tb_jk_op_arbiter.sv
// Directed bench: arbiter drives a real JK flop whose q is looped back,
// with an override that can pin q low to emulate external corruption.
`timescale 1ns/1ps
module tb_jk_op_arbiter;
    logic clk;
    logic reset;
    logic j, k;
    logic ff_q, ff_q_bar;
    logic force_q;
    logic q_fb;
    int   checks;
    int   errors;

    jk_req_if #(.NREQ(4), .IDW(2)) bus ();

    jk_op_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .j     (j),
        .k     (k),
        .q     (q_fb)
    );

    jkff u_ff (
        .clk   (clk),
        .j     (j),
        .k     (k),
        .q     (ff_q),
        .q_bar (ff_q_bar)
    );

    assign q_fb = force_q ? 1'b0 : ff_q;

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One full transaction for requester 0; q_exp is the flop value after the op
    task automatic op0(input string tag, input logic [1:0] opv, input logic q_exp);
        bus.req = 4'b0001;
        bus.op  = {6'b0, opv};
        step();
        chk({tag, "_grant"}, 32'(bus.grant), 32'h1);
        chk({tag, "_jk"}, 32'({j, k}), 32'(opv));
        bus.req = 4'b0000;
        step();
        chk({tag, "_q"}, 32'(ff_q), 32'(q_exp));
        chk({tag, "_done_early"}, 32'(bus.done), 32'h0);
        step();
        chk({tag, "_done"}, 32'(bus.done), 32'h1);
        chk({tag, "_err"}, 32'(bus.err), 32'h0);
        step();
        chk({tag, "_idle"}, 32'({bus.grant, bus.busy}), 32'h0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        force_q = 1'b0;
        bus.req = 4'b0000;
        bus.op  = 8'h00;

        // T1: reset held with all requests up; every op is "reset" so q gets defined
        bus.req = 4'b1111;
        bus.op  = 8'b01010101;
        step(); step(); step();
        chk("t1_grant_rst", 32'(bus.grant), 32'h0);
        chk("t1_jk_rst", 32'({j, k}), 32'h0);
        chk("t1_busy_rst", 32'(bus.busy), 32'h0);
        chk("t1_done_rst", 32'({bus.done, bus.err}), 32'h0);
        reset = 1'b1;
        step();
        chk("t1_grant", 32'(bus.grant), 32'h1);
        chk("t1_gid", 32'(bus.grant_id), 32'h0);
        chk("t1_busy", 32'(bus.busy), 32'h1);
        chk("t1_jk", 32'({j, k}), 32'h1);
        bus.req = 4'b0000;
        step();
        chk("t1_jk_clr", 32'({j, k}), 32'h0);
        chk("t1_q", 32'(ff_q), 32'h0);
        step();
        chk("t1_done", 32'(bus.done), 32'h1);
        chk("t1_err", 32'(bus.err), 32'h0);
        step();
        chk("t1_end", 32'({bus.grant, bus.busy, bus.done}), 32'h0);

        // T2: single ops on requester 0
        op0("t2_set",  2'b10, 1'b1);
        op0("t2_tgl1", 2'b11, 1'b0);
        op0("t2_tgl2", 2'b11, 1'b1);
        op0("t2_rst",  2'b01, 1'b0);
        op0("t2_hold", 2'b00, 1'b0);
        chk("t2_qbar", 32'(ff_q_bar), 32'h1);

        // T3: pointer back to 0, then everyone toggles
        reset = 1'b0;
        #0.2;
        reset = 1'b1;
        bus.req = 4'b1111;
        bus.op  = 8'hFF;
        for (int n = 0; n < 5; n++) begin
            step();
            chk($sformatf("t3_grant%0d", n), 32'(bus.grant), 32'(4'b0001 << (n % 4)));
            chk($sformatf("t3_gid%0d", n), 32'(bus.grant_id), 32'(n % 4));
            step();
            chk($sformatf("t3_q%0d", n), 32'(ff_q), 32'((n % 2 == 0) ? 1 : 0));
            step();
            chk($sformatf("t3_done%0d", n), 32'(bus.done), 32'(4'b0001 << (n % 4)));
            if (n == 4) bus.req = 4'b0000;
            step();
            chk($sformatf("t3_gap%0d", n), 32'(bus.grant), 32'h0);
        end

        // T4: requester 2 sets, then changes op and drops req mid-transaction
        bus.req = 4'b0100;
        bus.op  = 8'b00_10_00_00;
        step();
        chk("t4_grant", 32'(bus.grant), 32'h4);
        chk("t4_gid", 32'(bus.grant_id), 32'h2);
        chk("t4_jk", 32'({j, k}), 32'h2);
        bus.op  = 8'b00_01_00_00;
        bus.req = 4'b0000;
        step();
        chk("t4_q", 32'(ff_q), 32'h1);
        chk("t4_busy", 32'(bus.busy), 32'h1);
        step();
        chk("t4_done", 32'(bus.done), 32'h4);
        chk("t4_err", 32'(bus.err), 32'h0);
        step();

        // T5: q pinned low during VERIFY of a set on requester 1 (pointer at 3 wraps to 1)
        bus.req = 4'b0010;
        bus.op  = 8'b00_00_10_00;
        step();
        chk("t5_grant", 32'(bus.grant), 32'h2);
        bus.req = 4'b0000;
        step();
        force_q = 1'b1;
        step();
        chk("t5_done", 32'(bus.done), 32'h2);
        chk("t5_err", 32'(bus.err), 32'h1);
        force_q = 1'b0;
        step();
        chk("t5_err_clr", 32'(bus.err), 32'h0);
        chk("t5_done_clr", 32'(bus.done), 32'h0);

        // T6: reset lands in DRIVE of a toggle on requester 3
        bus.req = 4'b1000;
        bus.op  = 8'b11_00_00_00;
        step();
        chk("t6_grant", 32'(bus.grant), 32'h8);
        chk("t6_jk", 32'({j, k}), 32'h3);
        reset = 1'b0;
        #0.2;
        chk("t6_async", 32'({bus.grant, j, k, bus.busy}), 32'h0);
        bus.req = 4'b1111;
        bus.op  = 8'h00;
        step();
        chk("t6_no_done", 32'({bus.done, bus.err}), 32'h0);
        chk("t6_q_kept", 32'(ff_q), 32'h1);
        reset = 1'b1;
        step();
        chk("t6_regrant", 32'(bus.grant), 32'h1);
        step();
        step();
        chk("t6_hold_done", 32'(bus.done), 32'h1);
        chk("t6_hold_err", 32'(bus.err), 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
